// File: rtl/uart_receive_datapath.sv
// UART receive datapath: samples the serial line on FSM strobes, tracks frame length,
// and on the frame-end strobe assembles data/parity/framing/break status for the RX FIFO.
module uart_receive_datapath #(
  parameter int DATA_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       utrrst,
  input  logic       uart_rxd,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       rx_ready,
  input  logic       receive_shift_en,
  input  logic       error_check,
  input  logic       receive_frame_counter_en,
  input  logic       receive_frame_counter_clear,
  output logic       receive_done,
  output logic       rx_wr_en,
  output logic [7:0] rx_wr_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       overrun_err
);

  localparam int FW = DATA_MAX + 2;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [1:0]          wls_q, wls_d;
  logic                pen_q, pen_d;
  logic                eps_q, eps_d;
  logic                wrEn_q, wrEn_d;
  logic [7:0]          wrData_q, wrData_d;
  logic                pe_q, pe_d;
  logic                fe_q, fe_d;
  logic                bi_q, bi_d;
  logic                ovr_q, ovr_d;

  logic [CNT_W-1:0]    wordLen, frameLen, stopIdx;
  logic [DATA_MAX-1:0] dataBits;
  logic                parityBit, stopBit, parityErr, breakDet;
  logic                sampleEn, checkEn;

  // Frame geometry comes only from the config latched while the counter was cleared.
  always_comb begin
    wordLen  = CNT_W'(5) + CNT_W'(wls_q);
    stopIdx  = wordLen + CNT_W'(pen_q);
    frameLen = stopIdx + CNT_W'(1);
    sampleEn = receive_shift_en & receive_frame_counter_en & (cnt_q < frameLen);
    checkEn  = error_check & utrrst;
  end

  always_comb begin
    dataBits = '0;
    for (int i = 0; i < DATA_MAX; i++) begin
      dataBits[i] = frame_q[i] & (CNT_W'(i) < wordLen);
    end
    breakDet = 1'b1;
    for (int i = 0; i < FW; i++) begin
      if ((CNT_W'(i) < frameLen) && frame_q[i]) breakDet = 1'b0;
    end
    parityBit = frame_q[wordLen];
    stopBit   = frame_q[stopIdx];
    parityErr = pen_q & ((^dataBits ^ parityBit) != ~eps_q);
  end

  always_comb begin
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    wls_d    = wls_q;
    pen_d    = pen_q;
    eps_d    = eps_q;
    wrData_d = wrData_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    bi_d     = bi_q;
    if (receive_frame_counter_clear) begin
      cnt_d = '0;
      wls_d = wls;
      pen_d = pen;
      eps_d = eps;
    end else if (sampleEn) begin
      frame_d[cnt_q] = uart_rxd;
      cnt_d          = cnt_q + CNT_W'(1);
    end
    wrEn_d = checkEn & rx_ready;
    ovr_d  = checkEn & ~rx_ready;
    // Status fields only move on an actual FIFO write; an overrun leaves them untouched.
    if (wrEn_d) begin
      wrData_d = 8'(dataBits);
      pe_d     = parityErr;
      fe_d     = ~stopBit;
      bi_d     = breakDet;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q    <= '0;
      frame_q  <= '0;
      wls_q    <= '0;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      wrEn_q   <= 1'b0;
      wrData_q <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      bi_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      wls_q    <= wls_d;
      pen_q    <= pen_d;
      eps_q    <= eps_d;
      wrEn_q   <= wrEn_d;
      wrData_q <= wrData_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      bi_q     <= bi_d;
      ovr_q    <= ovr_d;
    end
  end

  assign receive_done = (cnt_q == frameLen);
  assign rx_wr_en     = wrEn_q;
  assign rx_wr_data   = wrData_q;
  assign rx_pe        = pe_q;
  assign rx_fe        = fe_q;
  assign rx_bi        = bi_q;
  assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_uart_receive_datapath.sv
// Directed bench for uart_receive_datapath: sends hand-built frames at 16x oversample
// and checks done timing, FIFO write contents, overrun and receiver-disable behaviour.
module tb_uart_receive_datapath;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       utrrst;
  logic       uart_rxd;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       rx_ready;
  logic       receive_shift_en;
  logic       error_check;
  logic       receive_frame_counter_en;
  logic       receive_frame_counter_clear;
  logic       receive_done;
  logic       rx_wr_en;
  logic [7:0] rx_wr_data;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;
  logic       overrun_err;

  int checks   = 0;
  int failures = 0;

  uart_receive_datapath dut (
    .pclk                        (pclk),
    .presetn                     (presetn),
    .utrrst                      (utrrst),
    .uart_rxd                    (uart_rxd),
    .wls                         (wls),
    .pen                         (pen),
    .eps                         (eps),
    .rx_ready                    (rx_ready),
    .receive_shift_en            (receive_shift_en),
    .error_check                 (error_check),
    .receive_frame_counter_en    (receive_frame_counter_en),
    .receive_frame_counter_clear (receive_frame_counter_clear),
    .receive_done                (receive_done),
    .rx_wr_en                    (rx_wr_en),
    .rx_wr_data                  (rx_wr_data),
    .rx_pe                       (rx_pe),
    .rx_fe                       (rx_fe),
    .rx_bi                       (rx_bi),
    .overrun_err                 (overrun_err)
  );

  always #5 pclk = ~pclk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Latch a new config through one clear cycle, then enter the receive phase.
  task automatic startFrame(input logic [1:0] w, input logic p, input logic e);
    wls = w;
    pen = p;
    eps = e;
    receive_shift_en = 1'b0;
    receive_frame_counter_clear = 1'b1;
    cycle();
    receive_frame_counter_clear = 1'b0;
    receive_shift_en = 1'b1;
  endtask

  // Drive bits[first +: count] LSB first, one sample strobe per 16 clocks.
  task automatic applyStimulus(input logic [9:0] bits, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      uart_rxd = bits[i];
      repeat (15) cycle();
      receive_frame_counter_en = 1'b1;
      cycle();
      receive_frame_counter_en = 1'b0;
    end
    uart_rxd = 1'b1;
  endtask

  // Frame-end strobe, then return to idle with the counter cleared.
  task automatic endFrame(input logic ready);
    error_check = 1'b1;
    rx_ready    = ready;
    cycle();
    error_check = 1'b0;
    rx_ready    = 1'b1;
    receive_shift_en = 1'b0;
    receive_frame_counter_clear = 1'b1;
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    checkOutput({tag, "_wr_en"}, 16'(rx_wr_en), 16'(1));
    checkOutput({tag, "_ovr"},   16'(overrun_err), 16'(0));
    checkOutput({tag, "_data"},  16'(rx_wr_data), 16'(d));
    checkOutput({tag, "_pe"},    16'(rx_pe), 16'(pe));
    checkOutput({tag, "_fe"},    16'(rx_fe), 16'(fe));
    checkOutput({tag, "_bi"},    16'(rx_bi), 16'(bi));
    cycle();
    checkOutput({tag, "_wr_pulse_end"}, 16'(rx_wr_en), 16'(0));
    checkOutput({tag, "_done_clr"},     16'(receive_done), 16'(0));
  endtask

  initial begin
    presetn = 1'b0;
    utrrst = 1'b1;
    uart_rxd = 1'b1;
    wls = 2'b00;
    pen = 1'b0;
    eps = 1'b0;
    rx_ready = 1'b1;
    receive_shift_en = 1'b0;
    error_check = 1'b0;
    receive_frame_counter_en = 1'b0;
    receive_frame_counter_clear = 1'b1;
    repeat (3) cycle();
    checkOutput("rst_wr_en", 16'(rx_wr_en), 16'(0));
    checkOutput("rst_data",  16'(rx_wr_data), 16'(0));
    checkOutput("rst_status", {13'd0, rx_pe, rx_fe, rx_bi}, 16'(0));
    checkOutput("rst_ovr",   16'(overrun_err), 16'(0));
    checkOutput("rst_done",  16'(receive_done), 16'(0));
    presetn = 1'b1;
    cycle();

    // 8N1, 0xA5 + stop 1 -> 9 bits 0x1A5
    startFrame(2'b11, 1'b0, 1'b0);
    applyStimulus(10'h1A5, 0, 8);
    checkOutput("8n1_done_early", 16'(receive_done), 16'(0));
    applyStimulus(10'h1A5, 8, 1);
    checkOutput("8n1_done", 16'(receive_done), 16'(1));
    applyStimulus(10'h000, 0, 1);
    checkOutput("8n1_extra_strobe_ignored", 16'(receive_done), 16'(1));
    endFrame(1'b1);
    checkWrite("8n1", 8'hA5, 1'b0, 1'b0, 1'b0);

    // 7E1, 0x41 has even ones so correct parity is 0; send 1 -> 0x41|0x80|0x100
    startFrame(2'b10, 1'b1, 1'b1);
    applyStimulus(10'h1C1, 0, 9);
    checkOutput("7e1_done", 16'(receive_done), 16'(1));
    endFrame(1'b1);
    checkWrite("7e1", 8'h41, 1'b1, 1'b0, 1'b0);

    // 5O1, 0x1F has odd ones so correct parity is 0; stop forced 0 -> 7 bits 0x01F
    startFrame(2'b00, 1'b1, 1'b0);
    applyStimulus(10'h01F, 0, 6);
    checkOutput("5o1_done_early", 16'(receive_done), 16'(0));
    applyStimulus(10'h01F, 6, 1);
    checkOutput("5o1_done", 16'(receive_done), 16'(1));
    endFrame(1'b1);
    checkWrite("5o1", 8'h1F, 1'b0, 1'b1, 1'b0);

    // Break on 8E1: ten zero bits
    startFrame(2'b11, 1'b1, 1'b1);
    applyStimulus(10'h000, 0, 10);
    checkOutput("brk_done", 16'(receive_done), 16'(1));
    endFrame(1'b1);
    checkWrite("brk", 8'h00, 1'b0, 1'b1, 1'b1);

    // Overrun: 8N1 0x3C with FIFO full; previous break entry must be retained
    startFrame(2'b11, 1'b0, 1'b0);
    applyStimulus(10'h13C, 0, 9);
    endFrame(1'b0);
    checkOutput("ovr_pulse", 16'(overrun_err), 16'(1));
    checkOutput("ovr_no_wr", 16'(rx_wr_en), 16'(0));
    checkOutput("ovr_data_kept", 16'(rx_wr_data), 16'(8'h00));
    checkOutput("ovr_bi_kept", 16'(rx_bi), 16'(1));
    cycle();
    checkOutput("ovr_pulse_end", 16'(overrun_err), 16'(0));

    // Receiver disabled after 4 samples: gated frame-end strobe, then discard
    startFrame(2'b11, 1'b0, 1'b0);
    applyStimulus(10'h1FF, 0, 4);
    utrrst = 1'b0;
    endFrame(1'b1);
    checkOutput("dis_no_wr", 16'(rx_wr_en), 16'(0));
    checkOutput("dis_no_ovr", 16'(overrun_err), 16'(0));
    checkOutput("dis_data_kept", 16'(rx_wr_data), 16'(8'h00));
    cycle();
    utrrst = 1'b1;

    // 8N1 0x5A; wls drops to 5 bits mid-frame but the latched 9-bit length holds
    startFrame(2'b11, 1'b0, 1'b0);
    applyStimulus(10'h15A, 0, 2);
    wls = 2'b00;
    applyStimulus(10'h15A, 2, 4);
    checkOutput("mid_wls_not_done_6", 16'(receive_done), 16'(0));
    applyStimulus(10'h15A, 6, 3);
    checkOutput("mid_wls_done_9", 16'(receive_done), 16'(1));
    endFrame(1'b1);
    checkWrite("re_en", 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receive_datapath.md
Name: uart_receive_datapath

Overview:
Receive datapath directly downstream of the UART receive control FSM. It samples uart_rxd on each frame-counter enable, counts the received bits, and raises receive_done to the FSM when the frame is complete. On error_check it assembles the data word and its parity, framing and break status, then writes one entry into the RX FIFO or flags overrun if the FIFO is full.

Parameters:
DATA_MAX, 8, maximum data bits per frame; the frame register is DATA_MAX+2 bits wide.
CNT_W, 4, width of the bit counter; must hold DATA_MAX+2.

Ports:
pclk  input  1  APB clock, rising edge.
presetn  input  1  asynchronous active-low reset.
utrrst  input  1  receiver enable.
uart_rxd  input  1  serial input line.
wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
pen  input  1  parity enable.
eps  input  1  even parity select: 1=even, 0=odd.
rx_ready  input  1  RX FIFO not full.
receive_shift_en  input  1  from FSM, high in RECEIVE.
error_check  input  1  from FSM, frame-end strobe.
receive_frame_counter_en  input  1  from FSM, sample strobe.
receive_frame_counter_clear  input  1  from FSM, high outside RECEIVE.
receive_done  output  1  to FSM, all frame bits sampled.
rx_wr_en  output  1  FIFO write strobe, one pclk wide.
rx_wr_data  output  8  received data, zero-extended.
rx_pe  output  1  parity error for this entry.
rx_fe  output  1  framing error for this entry.
rx_bi  output  1  break indication for this entry.
overrun_err  output  1  one-pclk pulse; frame dropped because FIFO full.

Behaviour:
- Reset: counter=0, frame register=0, latched config=0, rx_wr_en=0, rx_wr_data=0, rx_pe=rx_fe=rx_bi=0, overrun_err=0.
- Config latch: wls/pen/eps are captured every cycle that receive_frame_counter_clear=1. They are held while clear=0, so config changes mid-frame do not affect the frame in progress.
- Frame length: N = (5+wls) + pen + 1. Only the first stop bit is checked. N ranges from 6 to 10.
- Sampling: when receive_shift_en & receive_frame_counter_en & (cnt<N): frame[cnt] <= uart_rxd and cnt <= cnt+1. Bits are received LSB first. Strobes arriving when cnt==N are ignored.
- Clear: receive_frame_counter_clear=1 forces cnt=0. Clear takes priority over sampling. Frame register bits are not cleared; they are overwritten as the next frame is sampled.
- receive_done = (cnt==N). It is combinational from the counter and the latched config, and is deasserted in the cycle after clear.
- On error_check=1 (cycle T), the following are computed from frame[] and registered at T+1:
  - data = frame[wl-1:0], zero-extended to 8 bits.
  - pe = pen & (XOR(data,parity_bit) != ~eps). Even parity requires an XOR of 0; odd parity requires an XOR of 1.
  - fe = ~stop_bit, where stop_bit = frame[wl+pen].
  - bi = all N sampled bits are 0.
- Write: if rx_ready=1 at T, rx_wr_en=1 at T+1, with rx_wr_data/rx_pe/rx_fe/rx_bi valid in the same cycle. These fields hold their value until the next write.
- Overrun: if rx_ready=0 at T, then rx_wr_en=0, overrun_err=1 at T+1, and the data/status outputs are unchanged.
- Receiver disabled: utrrst=0 gates error_check. No write and no overrun occur while disabled. The FSM's clear then zeros the counter, so a partial frame is discarded.
- Back-to-back frames: error_check at T, clear at T+1, and the next frame starts sampling no earlier than T+2. There is no lost write between frames.
- Latency: last sample at cycle S, receive_done at S+1, error_check at S+1, FIFO write at S+2.

Test Plan:
- 8N1 with wls=11, pen=0, byte 0xA5 at 16 oversample -> receive_done after 9 samples; rx_wr_en one pulse with rx_wr_data=0xA5 and pe=fe=bi=0.
- 7E1 with wls=10, pen=1, eps=1, data 0x41, parity bit 1 (wrong) -> rx_wr_data=0x41, rx_pe=1, rx_fe=0.
- 5O1 with wls=00, pen=1, eps=0, data 0x1F, stop bit forced 0 -> rx_wr_data=0x1F, rx_fe=1, rx_pe=0.
- Break: rxd held 0 for a full 8E1 frame -> rx_wr_data=0x00, rx_bi=1, rx_fe=1.
- rx_ready=0 at error_check with byte 0x3C -> overrun_err pulses for 1 cycle, rx_wr_en stays 0, previous rx_wr_data retained.
- utrrst deasserted after 4 samples, then re-enabled and 0x5A sent -> no write for the aborted frame; the following frame is written as 0x5A. wls changed mid-frame -> the current frame still uses the latched length.
